// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter slice.
//   - state_e     : blitter sequencing states
//   - DEF_*       : default sprite geometry and grid pitch
//   - SCREEN_*    : framebuffer limits of the 160x120 VGA adapter
//   - cnt_width() : counter width for a dimension, never narrower than 1 bit
package sprite_pkg;

  localparam int DEF_SPR_W = 5;
  localparam int DEF_SPR_H = 5;
  localparam int DEF_TILE  = 5;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_raster_counter.sv
// Two-dimensional raster counter: column runs fastest, then row.
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : force (row, col) back to (0, 0); wins over enable
//   enable         : advance one position
//   col_idx        : current column, 0..SPR_W-1
//   row_idx        : current row, 0..SPR_H-1
//   last           : high at (SPR_H-1, SPR_W-1); the next advance wraps to (0, 0)
module sprite_raster_counter
  import sprite_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        enable,
  output logic [cnt_width(SPR_W)-1:0] col_idx,
  output logic [cnt_width(SPR_H)-1:0] row_idx,
  output logic                        last
);

  localparam int CW = cnt_width(SPR_W);
  localparam int RW = cnt_width(SPR_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(SPR_W - 1));
  assign row_end = (row_q == RW'(SPR_H - 1));
  assign last    = col_end && row_end;

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (enable) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments, and reset is sampled on
  // the clock edge only (synchronous), matching the rest of the codebase.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_idx = col_q;
  assign row_idx = row_q;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite plotter for the 160x120 VGA framebuffer. Draws an SPR_W x SPR_H
// bitmap at a grid cell, one pixel per clock, optionally erasing the
// previously drawn position first.
//   clock, reset_n        : clock and synchronous active-low reset
//   go                    : start request, honoured only when idle
//   erase_first           : erase the previous sprite position before drawing
//   transparent           : 1 = plot set bits only; 0 = 0-bits in bg_colour
//   tile_x, tile_y        : grid cell; pixel base = tile * TILE (wraps)
//   shape                 : bitmap, row 0 in the MSBs
//   colour, bg_colour     : foreground and background/erase colours
//   x, y, col, plot       : registered plot interface to the vga_adapter
//   busy                  : high while pixels are being streamed
//   done                  : one-cycle completion pulse
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H,
  parameter int TILE  = DEF_TILE,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   go,
  input  logic                   erase_first,
  input  logic                   transparent,
  input  logic [X_W-1:0]         tile_x,
  input  logic [Y_W-1:0]         tile_y,
  input  logic [SPR_W*SPR_H-1:0] shape,
  input  logic [COL_W-1:0]       colour,
  input  logic [COL_W-1:0]       bg_colour,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COL_W-1:0]       col,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int N  = SPR_W * SPR_H;
  localparam int IW = cnt_width(N);
  localparam int CW = cnt_width(SPR_W);
  localparam int RW = cnt_width(SPR_H);

  if (TILE < SPR_W || TILE < SPR_H) begin : g_tile_check
    $error("sprite_blitter: TILE must be at least SPR_W and SPR_H");
  end

  // Control state (reset)
  state_e           state_q, state_d;
  logic             prev_valid_q, prev_valid_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Job datapath (not reset; always loaded before use)
  logic [X_W-1:0]   base_x_q, base_x_d;
  logic [Y_W-1:0]   base_y_q, base_y_d;
  logic [X_W-1:0]   prev_x_q, prev_x_d;
  logic [Y_W-1:0]   prev_y_q, prev_y_d;
  logic [N-1:0]     shape_q, shape_d;
  logic [COL_W-1:0] fg_q, fg_d;
  logic [COL_W-1:0] bg_q, bg_d;
  logic             transp_q, transp_d;

  logic [CW-1:0]    col_idx;
  logic [RW-1:0]    row_idx;
  logic             last;
  logic             streaming;
  logic [IW-1:0]    pix_idx;

  assign streaming = (state_q == ERASE) || (state_q == DRAW);

  sprite_raster_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_raster (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q == IDLE),
    .enable  (streaming),
    .col_idx (col_idx),
    .row_idx (row_idx),
    .last    (last)
  );

  // Row 0 sits in the MSBs, so raster position n maps to bit N-1-n.
  assign pix_idx = IW'(N - 1) - (IW'(row_idx) * IW'(SPR_W) + IW'(col_idx));

  always_comb begin
    state_d      = state_q;
    prev_valid_d = prev_valid_q;
    x_d          = x_q;
    y_d          = y_q;
    col_d        = col_q;
    plot_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    shape_d      = shape_q;
    fg_d         = fg_q;
    bg_d         = bg_q;
    transp_d     = transp_q;

    unique case (state_q)
      IDLE: begin
        // done is registered, so the DONE phase is visible for one cycle
        // after the FSM is already back in IDLE; go is still refused then.
        if (go && !done_q) begin
          base_x_d = X_W'(32'(tile_x) * 32'(TILE));
          base_y_d = Y_W'(32'(tile_y) * 32'(TILE));
          shape_d  = shape;
          fg_d     = colour;
          bg_d     = bg_colour;
          transp_d = transparent;
          state_d  = (erase_first && prev_valid_q) ? ERASE : DRAW;
        end
      end
      ERASE: begin
        busy_d = 1'b1;
        x_d    = prev_x_q + X_W'(col_idx);
        y_d    = prev_y_q + Y_W'(row_idx);
        col_d  = bg_q;
        plot_d = 1'b1;
        if (last) state_d = DRAW;
      end
      DRAW: begin
        busy_d = 1'b1;
        x_d    = base_x_q + X_W'(col_idx);
        y_d    = base_y_q + Y_W'(row_idx);
        if (shape_q[pix_idx]) begin
          col_d  = fg_q;
          plot_d = 1'b1;
        end else if (!transp_q) begin
          col_d  = bg_q;
          plot_d = 1'b1;
        end
        if (last) begin
          prev_x_d     = base_x_q;
          prev_y_d     = base_y_q;
          prev_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // NOTE: job registers carry no reset: they are always written on go
  // before being read, and prev_x/prev_y are qualified by prev_valid.
  always_ff @(posedge clock) begin
    base_x_q <= base_x_d;
    base_y_q <= base_y_d;
    prev_x_q <= prev_x_d;
    prev_y_q <= prev_y_d;
    shape_q  <= shape_d;
    fg_q     <= fg_d;
    bg_q     <= bg_d;
    transp_q <= transp_d;
  end

  assign x    = x_q;
  assign y    = y_q;
  assign col  = col_q;
  assign plot = plot_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised sprite plotter for the 160x120 VGA framebuffer; successor to the fixed 5x5 grid drawer.
- Takes an SPR_W x SPR_H bitmap, a grid-cell position and colours, then streams one pixel per clock to the vga_adapter plot interface.
- New capabilities:
  - Optional erase of the previously drawn position before drawing (sprite move).
  - Transparent mode, where 0-bits are skipped.
  - busy/done handshake for an upstream game FSM.

Parameters:
- SPR_W, 5, sprite width in pixels.
- SPR_H, 5, sprite height in pixels.
- TILE, 5, grid pitch in pixels; base = tile index * TILE.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COL_W, 3, colour width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- go  in  1  start request; sampled only in IDLE.
- erase_first  in  1  erase the previous sprite position before drawing.
- transparent  in  1  1: plot only set bits; 0: plot all pixels, with 0-bits in bg_colour.
- tile_x  in  X_W  grid column.
- tile_y  in  Y_W  grid row.
- shape  in  SPR_W*SPR_H  bitmap; row 0 is in the MSBs.
- colour  in  COL_W  foreground colour.
- bg_colour  in  COL_W  background/erase colour.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- col  out  COL_W  pixel colour.
- plot  out  1  write strobe to the VGA adapter.
- busy  out  1  high in ERASE/DRAW.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (synchronous, on clock edge with reset_n=0):
  - state=IDLE; x, y, col, plot, busy, done = 0.
  - prev_valid=0; row/column counters = 0.
- States:
  - IDLE: on go, latch the following and clear counters:
    - base_x = tile_x*TILE and base_y = tile_y*TILE, truncated to X_W/Y_W (wrap, no saturation).
    - shape, colour, bg_colour, transparent.
  - IDLE, next state after go:
    - ERASE if erase_first && prev_valid.
    - Otherwise DRAW.
  - ERASE: one pixel per cycle at prev_x+c, prev_y+r, col=bg_colour, plot=1 for every pixel. After pixel (SPR_H-1, SPR_W-1): counters clear, go to DRAW.
  - DRAW: one pixel per cycle at base_x+c, base_y+r.
    - Pixel bit index = SPR_W*SPR_H-1-(r*SPR_W+c).
    - bit=1: col=colour, plot=1.
    - bit=0, transparent=0: col=bg_colour, plot=1.
    - bit=0, transparent=1: plot=0, but the cycle is still consumed.
    - After the last pixel: prev_x/prev_y <= base_x/base_y, prev_valid <= 1, go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE. go is ignored in DONE.
- Raster order: column fastest, then row.
- Timing and outputs:
  - x, y, col and plot are registered outputs.
  - If go is sampled at edge k, the first pixel is presented after edge k+1.
  - DRAW lasts SPR_W*SPR_H cycles; ERASE lasts the same.
- busy is high exactly during ERASE/DRAW. go while busy or done is ignored; no queueing.
- plot=0 in IDLE and DONE.
- Reset mid-operation: returns to IDLE next edge, plot=0, prev_valid=0, and the partial sprite is left on screen.
- Width rules:
  - x/y sums are truncated modulo 2^X_W / 2^Y_W.
  - Counters are $clog2(SPR_W) / $clog2(SPR_H) bits.
- Elaboration check: TILE >= SPR_W and TILE >= SPR_H.

Decomposition:
- Package sprite_pkg:
  - State localparams IDLE/ERASE/DRAW/DONE.
  - Default SPR_W/SPR_H/TILE.
  - Screen limits 160/120.
- Sub-module sprite_raster_counter(clock, reset_n, clear, enable, col_idx, row_idx, last):
  - Generic 2-D counter; last is high at (SPR_H-1, SPR_W-1).
  - Wraps to (0,0) after last.

Test Plan:
- Reset held 3 cycles, with go=1 meanwhile -> plot=0, busy=0, done=0, x=0, y=0 throughout; no plots after release until a fresh go.
- Opaque draw, default parameters:
  - Stimulus: go, tile (2,3), shape 25'b0111011111110001111101110, colour 3'b110, bg 3'b000, transparent=0.
  - Response: 25 consecutive plots over x 10..14, y 15..19, row-major.
  - First pixel (10,15) col=000; pixel (11,15) col=110.
  - done pulses on the cycle after (14,19).
- Transparent draw, same shape, transparent=1 -> busy high 25 cycles, exactly 18 plot pulses, all col=110; no plot at (10,15) or (14,15).
- Move:
  - Stimulus: after the opaque draw at (2,3), go with erase_first=1 and tile (3,3).
  - Response: 25 plots col=000 over x 10..14, y 15..19, then 25 draw pixels over x 15..19; busy high 50 cycles; one done pulse.
- erase_first=1 as the first go after reset -> no ERASE phase; busy high 25 cycles.
- Interference during DRAW:
  - go pulsed mid-DRAW -> ignored, exactly 25 pixels.
  - reset_n=0 at pixel 12 -> plot=0 next cycle.
  - Subsequent go with erase_first=1 -> no ERASE phase.
